cb_filter_seq: RTL and testbench

- Serialised counting Bloom filter that consumes `cb_filter_pkg::cb_seed_t` seeds.
- Evaluates one seeded hash per cycle and reads/updates one counter per cycle, so no parallel counter ports are needed.
- Exposes a valid/ready request channel (insert, remove, lookup) and a valid/ready response channel.
- Sits beside caches and ID trackers as an area-lean, approximate membership tracker.

---
 rtl/cb_filter_seq.sv | 208 ++++++++++++++++++++
 tb/tb_cb_filter_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_filter_seq.sv
// Serialised counting Bloom filter: one seeded hash and one counter access per cycle.
// Optional single-cycle counter clear port enabled by defining CB_FILTER_SEQ_CLEAR_EN.
package cb_filter_pkg;
    typedef struct packed {
        int unsigned PermuteSeed;
        int unsigned XorSeed;
    } cb_seed_t;
endpackage

module cb_filter_seq
    import cb_filter_pkg::*;
#(
    parameter int unsigned NoHashes  = 3,
    parameter int unsigned InpWidth  = 32,
    parameter int unsigned HashWidth = 4,
    parameter int unsigned CntWidth  = 4,
    parameter int unsigned ItemWidth = 16,
    parameter cb_seed_t [NoHashes-1:0] Seeds = {
        32'd299034753, 32'd4094834,
        32'd19921030,  32'd995713,
        32'd294388,    32'd65146511
    }
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [InpWidth-1:0]  req_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic                 rsp_err_o,
    output logic [ItemWidth-1:0] items_o,
    output logic                 empty_o,
    output logic                 full_o
`ifdef CB_FILTER_SEQ_CLEAR_EN
    ,
    input  logic                 clear_i
`endif
);

    localparam int unsigned NoCnt    = 2**HashWidth;
    localparam int unsigned NoChunks = (InpWidth + HashWidth - 1) / HashWidth;
    localparam int unsigned KW       = (NoHashes > 1) ? $clog2(NoHashes) : 1;
    localparam logic [KW-1:0] LastK  = KW'(NoHashes - 1);

    localparam logic [1:0] OpInsert = 2'd1;
    localparam logic [1:0] OpRemove = 2'd2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    function automatic logic [HashWidth-1:0] hash_idx(input logic [InpWidth-1:0] key,
                                                      input cb_seed_t seed);
        logic [InpWidth-1:0]           x;
        logic [2*InpWidth-1:0]         dbl;
        logic [NoChunks*HashWidth-1:0] padded;
        logic [HashWidth-1:0]          acc;
        int unsigned                   rot;
        x   = key ^ InpWidth'(seed.XorSeed);
        rot = seed.PermuteSeed % InpWidth;
        // Upper half of the doubled word shifted left is the rotate-left of x.
        dbl    = {x, x} << rot;
        padded = '0;
        padded[InpWidth-1:0] = dbl[2*InpWidth-1:InpWidth];
        acc = '0;
        for (int c = 0; c < NoChunks; c++) begin
            acc ^= padded[c*HashWidth +: HashWidth];
        end
        return acc;
    endfunction

    function automatic logic [CntWidth-1:0] cnt_inc(input logic [CntWidth-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Saturated counters are sticky: once all-ones they never decrement.
    function automatic logic [CntWidth-1:0] cnt_dec(input logic [CntWidth-1:0] c);
        return ((&c) || (c == '0)) ? c : c - 1'b1;
    endfunction

    function automatic logic [ItemWidth-1:0] item_inc(input logic [ItemWidth-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [ItemWidth-1:0] item_dec(input logic [ItemWidth-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [1:0]           state;
    logic [KW-1:0]        k_q;
    logic [1:0]           op_q;
    logic [InpWidth-1:0]  key_q;
    logic                 hit_acc;
    logic                 sat_acc;
    logic [ItemWidth-1:0] items_q;
    logic [CntWidth-1:0]  cnt [NoCnt];

    logic [HashWidth-1:0] idx;
    logic [CntWidth-1:0]  cnt_cur;
    logic                 hit_next;
    logic                 clear_go;
    logic                 accept;

`ifdef CB_FILTER_SEQ_CLEAR_EN
    assign clear_go = (state == IDLE) && clear_i;
`else
    assign clear_go = 1'b0;
`endif

    assign req_ready_o = (state == IDLE) && !clear_go;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        idx = '0;
        for (int k = 0; k < NoHashes; k++) begin
            if (k_q == KW'(k)) begin
                idx = hash_idx(key_q, Seeds[k]);
            end
        end
    end

    assign cnt_cur  = cnt[idx];
    assign hit_next = hit_acc && (cnt_cur != '0);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            key_q <= req_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            k_q     <= '0;
            op_q    <= '0;
            hit_acc <= 1'b0;
            sat_acc <= 1'b0;
            items_q <= '0;
            for (int i = 0; i < NoCnt; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear_go) begin
                        items_q <= '0;
                        for (int i = 0; i < NoCnt; i++) begin
                            cnt[i] <= '0;
                        end
                    end else if (accept) begin
                        op_q    <= req_op_i;
                        k_q     <= '0;
                        hit_acc <= 1'b1;
                        sat_acc <= 1'b0;
                        state   <= (req_op_i == OpInsert) ? UPDATE : CHECK;
                    end
                end
                CHECK: begin
                    hit_acc <= hit_next;
                    if (k_q == LastK) begin
                        if ((op_q == OpRemove) && hit_next) begin
                            k_q   <= '0;
                            state <= UPDATE;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                UPDATE: begin
                    if (op_q == OpInsert) begin
                        cnt[idx] <= cnt_inc(cnt_cur);
                        if (&cnt_cur) begin
                            sat_acc <= 1'b1;
                        end
                    end else begin
                        cnt[idx] <= cnt_dec(cnt_cur);
                    end
                    if (k_q == LastK) begin
                        items_q <= (op_q == OpInsert) ? item_inc(items_q) : item_dec(items_q);
                        state   <= RESP;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_hit_o   = rsp_valid_o && ((op_q == OpInsert) || hit_acc);
    assign rsp_err_o   = rsp_valid_o && ((op_q == OpInsert) ? sat_acc :
                                         (op_q == OpRemove) ? !hit_acc : 1'b0);
    assign items_o     = items_q;
    assign empty_o     = (items_q == '0);
    assign full_o      = &items_q;

endmodule

// File: tb/tb_cb_filter_seq.sv
// Bench for cb_filter_seq: responses are scored against a reference model of the counter bank
// and item count, queued when each request is driven and popped when the response appears.
module tb_cb_filter_seq;

    localparam int NH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic        rsp_err;
    logic [15:0] items;
    logic        empty;
    logic        full;
`ifdef CB_FILTER_SEQ_CLEAR_EN
    logic        clear = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    cb_filter_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_hit_o   (rsp_hit),
        .rsp_err_o   (rsp_err),
        .items_o     (items),
        .empty_o     (empty),
        .full_o      (full)
`ifdef CB_FILTER_SEQ_CLEAR_EN
        ,
        .clear_i     (clear)
`endif
    );

    always #5 clk = ~clk;

    int unsigned perm [NH] = '{294388, 19921030, 299034753};
    int unsigned xr   [NH] = '{65146511, 995713, 4094834};

    typedef struct {
        logic        hit;
        logic        err;
        int          lat;
        logic [15:0] items;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  mcnt [16];
    logic [15:0] mitems;

    function automatic logic [3:0] mhash(logic [31:0] key, int k);
        logic [31:0] x, r;
        logic [3:0]  a;
        int          rot;
        x   = key ^ xr[k];
        rot = int'(perm[k] % 32);
        r   = (rot == 0) ? x : ((x << rot) | (x >> (32 - rot)));
        a   = '0;
        for (int i = 0; i < 8; i++) a ^= r[i*4 +: 4];
        return a;
    endfunction

    function automatic exp_t model_op(logic [1:0] op, logic [31:0] key);
        exp_t       e;
        logic       all_nz;
        logic [3:0] id;
        all_nz = 1'b1;
        for (int k = 0; k < NH; k++) if (mcnt[mhash(key, k)] == 4'h0) all_nz = 1'b0;
        e.err = 1'b0;
        e.lat = NH + 1;
        if (op == 2'd1) begin
            e.hit = 1'b1;
            for (int k = 0; k < NH; k++) begin
                id = mhash(key, k);
                if (mcnt[id] == 4'hF) e.err = 1'b1;
                else mcnt[id] = mcnt[id] + 4'd1;
            end
            if (mitems != 16'hFFFF) mitems = mitems + 16'd1;
        end else if (op == 2'd2) begin
            e.hit = all_nz;
            e.err = !all_nz;
            if (all_nz) begin
                e.lat = 2 * NH + 1;
                for (int k = 0; k < NH; k++) begin
                    id = mhash(key, k);
                    if (mcnt[id] != 4'hF && mcnt[id] != 4'h0) mcnt[id] = mcnt[id] - 4'd1;
                end
                if (mitems != 16'd0) mitems = mitems - 16'd1;
            end
        end else begin
            e.hit = all_nz;
        end
        e.items = mitems;
        return e;
    endfunction

    function automatic logic [26:0] pack_exp(exp_t e);
        return {1'b1, e.hit, e.err, 8'(e.lat), e.items};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 4'h0;
        mitems = '0;
        exp_q.delete();
    endfunction

    // Observed vector: {response_seen, hit, err, latency[7:0], items}
    task automatic run_op(input logic [1:0] op, input logic [31:0] key, output logic [26:0] obs);
        int w;
        int lat;
        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        req_op = op;
        req_data = key;
        req_valid = 1'b1;
        exp_q.push_back(model_op(op, key));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        obs = {rsp_valid, rsp_hit, rsp_err, 8'(lat), items};
        if (rsp_valid && rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_err, empty, full} !== 6'b100010) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=100010",
                     {req_ready, rsp_valid, rsp_hit, rsp_err, empty, full});
        end
        checks++;
        if (items !== 16'd0) begin failures++; $display("FAIL reset_items got=%h want=0000", items); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lookup_empty();
        logic [26:0] obs;
        exp_t ex;
        run_op(2'd0, 32'hDEADBEEF, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL lookup_empty got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'd4, 16'd0}) begin failures++; $display("FAIL lookup_empty_const got=%h want=%h", obs, {1'b1, 1'b0, 1'b0, 8'd4, 16'd0}); end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL empty_after_lookup got=%b want=1", empty); end
    endtask

    task automatic test_insert_lookup();
        logic [26:0] obs;
        exp_t ex;
        run_op(2'd1, 32'hDEADBEEF, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL insert got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'd4, 16'd1}) begin failures++; $display("FAIL insert_const got=%h want=%h", obs, {1'b1, 1'b1, 1'b0, 8'd4, 16'd1}); end
        run_op(2'd0, 32'hDEADBEEF, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL lookup_after_insert got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (obs[25] !== 1'b1) begin failures++; $display("FAIL lookup_hit got=%b want=1", obs[25]); end
    endtask

    task automatic test_remove();
        logic [26:0] obs;
        exp_t ex;
        run_op(2'd2, 32'hDEADBEEF, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL remove got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'd7, 16'd0}) begin failures++; $display("FAIL remove_const got=%h want=%h", obs, {1'b1, 1'b1, 1'b0, 8'd7, 16'd0}); end
        run_op(2'd0, 32'hDEADBEEF, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL lookup_after_remove got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL empty_after_remove got=%b want=1", empty); end
    endtask

    task automatic test_remove_absent();
        logic [26:0] obs;
        exp_t ex;
        run_op(2'd2, 32'h00000001, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL remove_absent got=%h want=%h", obs, pack_exp(ex)); end
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'd4, 16'd0}) begin failures++; $display("FAIL remove_absent_const got=%h want=%h", obs, {1'b1, 1'b0, 1'b1, 8'd4, 16'd0}); end
    endtask

    task automatic test_saturation();
        logic [26:0] obs;
        exp_t ex;
        for (int i = 0; i < 16; i++) begin
            run_op(2'd1, 32'h5, obs);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== pack_exp(ex)) begin failures++; $display("FAIL sat_insert_%0d got=%h want=%h", i, obs, pack_exp(ex)); end
        end
        checks++;
        if (obs[24] !== 1'b1) begin failures++; $display("FAIL sat_err_16th got=%b want=1", obs[24]); end
        for (int i = 0; i < 16; i++) begin
            run_op(2'd2, 32'h5, obs);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== pack_exp(ex)) begin failures++; $display("FAIL sat_remove_%0d got=%h want=%h", i, obs, pack_exp(ex)); end
        end
        run_op(2'd0, 32'h5, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs[26:24] !== 3'b110) begin failures++; $display("FAIL sticky_lookup got=%b want=110", obs[26:24]); end
    endtask

    task automatic test_back_to_back();
        logic [26:0] obs;
        exp_t ex;
        logic [31:0] keys [5] = '{32'hDEADBEEF, 32'h5, 32'h1, 32'hCAFEF00D, 32'h12345678};
        logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            run_op(op, keys[$urandom_range(0, 4)], obs);
            ex = exp_q.pop_front();
            checks++;
            if (obs !== pack_exp(ex)) begin failures++; $display("FAIL b2b_%0d op=%0d got=%h want=%h", i, op, obs, pack_exp(ex)); end
        end
    endtask

    task automatic test_hold();
        exp_t ex;
        int w;
        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        rsp_ready = 1'b0;
        req_op = 2'd1;
        req_data = 32'hA5A5_0F0F;
        req_valid = 1'b1;
        exp_q.push_back(model_op(2'd1, 32'hA5A5_0F0F));
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 50) begin @(posedge clk); #1; w++; end
        ex = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_hit, rsp_err, req_ready, items} !== {1'b1, ex.hit, ex.err, 1'b0, ex.items}) begin
                failures++;
                $display("FAIL hold_%0d got=%h want=%h", i, {rsp_valid, rsp_hit, rsp_err, req_ready, items},
                         {1'b1, ex.hit, ex.err, 1'b0, ex.items});
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b want=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_reset_mid_update();
        logic [26:0] obs;
        exp_t ex;
        req_op = 2'd1;
        req_data = 32'h0000_1234;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_err, empty, full, items} !== {6'b100010, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid_update got=%h want=%h", {req_ready, rsp_valid, rsp_hit, rsp_err, empty, full, items},
                     {6'b100010, 16'd0});
        end
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(2'd0, 32'h5, obs);
        ex = exp_q.pop_front();
        checks++;
        if (obs !== pack_exp(ex)) begin failures++; $display("FAIL lookup_after_reset got=%h want=%h", obs, pack_exp(ex)); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lookup_empty();
        test_insert_lookup();
        test_remove();
        test_remove_absent();
        test_saturation();
        test_back_to_back();
        test_hold();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
